// File: rtl/instr_fetch_unit.sv
// Fetch front end for the picoMIPS core: drives the program ROM from the PC,
// captures each returned word together with its address tag in a 2-entry FIFO
// and hands it to the decoder over a valid/ready handshake. A fetch is issued
// only when a FIFO slot is guaranteed, so returning ROM data is never dropped.
module instr_fetch_unit #(
  parameter int unsigned P_SIZE  = 6,
  parameter int unsigned I_WIDTH = 16,
  parameter bit          WRAP    = 1'b1
) (
  input  logic               clk,
  input  logic               nRst,
  input  logic [P_SIZE-1:0]  pcAddr,
  output logic               pcInc,
  output logic [P_SIZE-1:0]  romAddr,
  input  logic [I_WIDTH-1:0] romData,
  input  logic               run,
  output logic [I_WIDTH-1:0] instr,
  output logic [P_SIZE-1:0]  instrAddr,
  output logic               instrValid,
  input  logic               instrReady,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                flag_q, flag_d;
  logic [2:0]          count_q, count_d;
  logic                inflight_q, inflight_d;
  logic [P_SIZE-1:0]   tag_q, tag_d;
  logic [I_WIDTH-1:0]  head_data_q, head_data_d;
  logic [P_SIZE-1:0]   head_addr_q, head_addr_d;
  logic [I_WIDTH-1:0]  tail_data_q, tail_data_d;
  logic [P_SIZE-1:0]   tail_addr_q, tail_addr_d;

  logic                pop;
  logic                push;
  logic [2:0]          space;
  logic [2:0]          occ_after_pop;
  logic                issue;
  logic                last_addr;

  // Handshake and issue qualification: a slot freed by this cycle's pop counts
  // as space, which is what allows one fetch per cycle with the decoder ready.
  always_comb begin
    instrValid    = (count_q != 3'd0);
    pop           = instrValid && instrReady;
    push          = inflight_q;
    space         = 3'd2 - count_q - {2'b00, inflight_q} + {2'b00, pop};
    issue         = (state_q == S_FETCH) && run && (space != 3'd0);
    last_addr     = (pcAddr == '1);
    occ_after_pop = count_q - {2'b00, pop};
    pcInc         = issue;
    romAddr       = pcAddr;
    instr         = head_data_q;
    instrAddr     = head_addr_q;
    done          = (state_q == S_DONE);
  end

  // Control FSM next state; the DONE flag records that the last address was issued.
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (issue && (WRAP == 1'b0) && last_addr) begin
          state_d = S_DRAIN;
          flag_d  = 1'b1;
        end else if (!run) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((count_q == 3'd0) && !inflight_q) begin
          state_d = flag_q ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!run) begin
          state_d = S_IDLE;
          flag_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch tracking and FIFO update. A pop shifts the tail into the head; the
  // returning word then lands in whichever slot is first free after that pop.
  always_comb begin
    inflight_d  = issue;
    tag_d       = issue ? pcAddr : tag_q;
    count_d     = count_q + {2'b00, push} - {2'b00, pop};
    head_data_d = head_data_q;
    head_addr_d = head_addr_q;
    tail_data_d = tail_data_q;
    tail_addr_d = tail_addr_q;
    if (pop) begin
      head_data_d = tail_data_q;
      head_addr_d = tail_addr_q;
    end
    if (push) begin
      if (occ_after_pop == 3'd0) begin
        head_data_d = romData;
        head_addr_d = tag_q;
      end else begin
        tail_data_d = romData;
        tail_addr_d = tag_q;
      end
    end
  end

  // State registers; reset discards buffered and in-flight words.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= S_IDLE;
      flag_q      <= 1'b0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      tag_q       <= '0;
      head_data_q <= '0;
      head_addr_q <= '0;
      tail_data_q <= '0;
      tail_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      flag_q      <= flag_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      head_data_q <= head_data_d;
      head_addr_q <= head_addr_d;
      tail_data_q <= tail_data_d;
      tail_addr_q <= tail_addr_d;
    end
  end

  // A returning word must always find a free slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!nRst)
    !(inflight_q && (count_q == 3'd2)));

  // Occupancy stays within the two entries.
  a_count_range: assert property (@(posedge clk) disable iff (!nRst)
    count_q <= 3'd2);

  // The head is held while the decoder stalls.
  a_hold_head: assert property (@(posedge clk) disable iff (!nRst)
    (instrValid && !instrReady) |=> ($stable(instr) && $stable(instrAddr)));

  // Fetches are issued only from FETCH.
  a_issue_state: assert property (@(posedge clk) disable iff (!nRst)
    pcInc |-> (state_q == S_FETCH));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a wrapping instance driven through directed and
// random-ready phases against a stream scoreboard, plus a non-wrapping
// instance exercising the DONE path.
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nRst = 1'b1;

  logic [5:0]  pcAddr, romAddr, instrAddr;
  logic        pcInc, run, instrValid, instrReady, done;
  logic [15:0] romData, instr;

  logic [5:0]  pcAddr0, romAddr0, instrAddr0;
  logic        pcInc0, run0, instrValid0, ready0, done0;
  logic [15:0] romData0, instr0;

  logic [15:0] rom [64];
  logic        pc_load, pc0_load;
  logic [5:0]  pc_load_val, pc0_load_val;

  instr_fetch_unit #(.P_SIZE(6), .I_WIDTH(16), .WRAP(1'b1)) u_dut (
    .clk(clk), .nRst(nRst), .pcAddr(pcAddr), .pcInc(pcInc), .romAddr(romAddr),
    .romData(romData), .run(run), .instr(instr), .instrAddr(instrAddr),
    .instrValid(instrValid), .instrReady(instrReady), .done(done)
  );

  instr_fetch_unit #(.P_SIZE(6), .I_WIDTH(16), .WRAP(1'b0)) u_dut0 (
    .clk(clk), .nRst(nRst), .pcAddr(pcAddr0), .pcInc(pcInc0), .romAddr(romAddr0),
    .romData(romData0), .run(run0), .instr(instr0), .instrAddr(instrAddr0),
    .instrValid(instrValid0), .instrReady(ready0), .done(done0)
  );

  // Program counters and synchronous ROM environment.
  always @(posedge clk) begin
    if (pc_load) pcAddr <= pc_load_val;
    else if (pcInc) pcAddr <= pcAddr + 6'd1;
    if (pc0_load) pcAddr0 <= pc0_load_val;
    else if (pcInc0) pcAddr0 <= pcAddr0 + 6'd1;
    romData  <= rom[romAddr];
    romData0 <= rom[romAddr0];
  end

  int          total, bad;
  int          issued, delivered;
  bit          inflight_m;
  logic [5:0]  exp_addr;
  bit          prev_stall;
  logic [15:0] prev_instr;
  logic [5:0]  prev_iaddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_sb();
    issued     = 0;
    delivered  = 0;
    inflight_m = 1'b0;
    prev_stall = 1'b0;
    exp_addr   = pcAddr;
  endtask

  task automatic settle(input bit r, input bit rdy);
    run        = r;
    instrReady = rdy;
    #1;
  endtask

  // Stream scoreboard: words come out as consecutive addresses, each with its
  // ROM contents; occupancy follows from pulses issued minus words delivered.
  task automatic adv(input bit chk_issue);
    int ecount;
    bit p;
    ecount = issued - delivered - int'(inflight_m);
    chk("romAddr_eq_pc", 32'(romAddr), 32'(pcAddr));
    chk("occupancy_le2", 32'(ecount <= 2), 32'd1);
    chk("instrValid", 32'(instrValid), 32'(ecount != 0));
    if (prev_stall) begin
      chk("hold_instr", 32'(instr), 32'(prev_instr));
      chk("hold_addr", 32'(instrAddr), 32'(prev_iaddr));
    end
    p = instrValid && instrReady;
    if (chk_issue)
      chk("pcInc_rule", 32'(pcInc), 32'((2 - ecount - int'(inflight_m) + int'(p)) > 0));
    if (p) begin
      chk("deliv_addr", 32'(instrAddr), 32'(exp_addr));
      chk("deliv_data", 32'(instr), 32'(rom[exp_addr]));
      exp_addr = exp_addr + 6'd1;
      delivered++;
    end
    prev_stall = instrValid && !instrReady;
    prev_instr = instr;
    prev_iaddr = instrAddr;
    issued     = issued + int'(pcInc);
    inflight_m = pcInc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit ld, input logic [5:0] v);
    nRst = 1'b0;
    #1;
    chk("rst_pcInc", 32'(pcInc), 32'd0);
    chk("rst_instrValid", 32'(instrValid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_instrAddr", 32'(instrAddr), 32'd0);
    pc_load     = ld;
    pc_load_val = v;
    @(posedge clk);
    #1;
    pc_load = 1'b0;
    nRst    = 1'b1;
    reset_sb();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_inc, got, n0, extra;
    bit hit63, finished;
    logic [5:0] pc_before, exp0, a6;

    total = 0; bad = 0;
    run = 1'b0; instrReady = 1'b0; run0 = 1'b0; ready0 = 1'b0;
    pc_load = 1'b0; pc_load_val = '0;
    pc0_load = 1'b1; pc0_load_val = 6'd60;
    for (int i = 0; i < 64; i++) rom[i] = 16'(16'h100 + i);
    @(posedge clk);
    #1;
    pc0_load = 1'b0;

    // 1: streaming from reset with the decoder always ready
    do_reset(1'b1, 6'd0);
    chk("rst_pcInc0", 32'(pcInc0), 32'd0);
    for (int i = 0; i < 12; i++) begin
      settle(1'b1, 1'b1);
      chk("t1_pcInc", 32'(pcInc), 32'(i >= 1));
      chk("t1_valid", 32'(instrValid), 32'(i >= 3));
      if (i >= 3) begin
        chk("t1_addr", 32'(instrAddr), 32'(i - 3));
        chk("t1_instr", 32'(instr), 32'(16'h100 + i - 3));
      end
      adv(i >= 1);
    end

    // 2: decoder stalled, then released
    do_reset(1'b1, 6'd0);
    stall_inc = 0;
    for (int i = 0; i < 10; i++) begin
      settle(1'b1, 1'b0);
      stall_inc += int'(pcInc);
      if (i >= 3) begin
        chk("t2_valid", 32'(instrValid), 32'd1);
        chk("t2_instr_held", 32'(instr), 32'h100);
        chk("t2_addr_held", 32'(instrAddr), 32'd0);
      end
      adv(i >= 1);
    end
    chk("t2_pulses", 32'(stall_inc), 32'd2);
    got = 0;
    for (int i = 0; i < 6; i++) begin
      settle(1'b1, 1'b1);
      if (instrValid && got < 3) begin
        chk("t2_seq", 32'(instr), 32'(16'h100 + got));
        got++;
      end
      adv(1'b1);
    end
    chk("t2_got", 32'(got), 32'd3);

    // 3: random decoder readiness, then drain
    for (int i = 0; i < 200; i++) begin
      settle(1'b1, 1'($urandom_range(0, 1)));
      adv(1'b1);
    end
    for (int i = 0; i < 20; i++) begin
      settle(1'b0, 1'b1);
      chk("t3_no_issue", 32'(pcInc), 32'd0);
      adv(1'b0);
      if (issued == delivered && !inflight_m) break;
    end
    chk("t3_balance", 32'(delivered), 32'(issued));
    for (int i = 0; i < 2; i++) begin
      settle(1'b0, 1'b1);
      adv(1'b0);
    end

    // 5: wrap-around with no bubble
    pc_load = 1'b1; pc_load_val = 6'd62;
    settle(1'b0, 1'b1);
    adv(1'b0);
    pc_load = 1'b0;
    exp_addr = pcAddr;
    for (int i = 0; i < 8; i++) begin
      settle(1'b1, 1'b1);
      chk("t5_pcInc", 32'(pcInc), 32'(i >= 1));
      if (i >= 3 && i <= 6) begin
        a6 = 6'(62 + i - 3);
        chk("t5_valid", 32'(instrValid), 32'd1);
        chk("t5_addr", 32'(instrAddr), 32'(a6));
      end
      adv(i >= 1);
    end

    // 6: reset with the FIFO full
    for (int i = 0; i < 4; i++) begin
      settle(1'b1, 1'b0);
      adv(1'b1);
    end
    settle(1'b1, 1'b0);
    chk("t6_full_noissue", 32'(pcInc), 32'd0);
    chk("t6_full_valid", 32'(instrValid), 32'd1);
    do_reset(1'b0, 6'd0);
    pc_before = pcAddr;
    for (int i = 0; i < 10; i++) begin
      settle(1'b1, 1'b1);
      if (i == 0) chk("t6_idle_first", 32'(pcInc), 32'd0);
      if (i == 1) begin
        chk("t6_restart_inc", 32'(pcInc), 32'd1);
        chk("t6_restart_addr", 32'(romAddr), 32'(pc_before));
      end
      adv(i >= 1);
    end
    for (int i = 0; i < 20; i++) begin
      settle(1'b0, 1'b1);
      adv(1'b0);
      if (issued == delivered && !inflight_m) break;
    end
    chk("t6_balance", 32'(delivered), 32'(issued));

    // 4: non-wrapping instance stops after address 63 and reports done
    hit63 = 1'b0; extra = 0; n0 = 0; exp0 = 6'd60; finished = 1'b0;
    for (int i = 0; i < 30 && !finished; i++) begin
      run0 = 1'b1; ready0 = 1'b1;
      settle(1'b0, 1'b1);
      if (done0) finished = 1'b1;
      else begin
        if (pcInc0) begin
          if (hit63) extra++;
          if (pcAddr0 == 6'd63) hit63 = 1'b1;
        end
        if (instrValid0) begin
          chk("t4_addr", 32'(instrAddr0), 32'(exp0));
          chk("t4_data", 32'(instr0), 32'(rom[exp0]));
          exp0 = exp0 + 6'd1;
          n0++;
        end
      end
      adv(1'b0);
    end
    chk("t4_done_seen", 32'(finished), 32'd1);
    chk("t4_delivered", 32'(n0), 32'd4);
    chk("t4_extra_inc", 32'(extra), 32'd0);
    chk("t4_hit63", 32'(hit63), 32'd1);
    run0 = 1'b0;
    settle(1'b0, 1'b1);
    chk("t4_done_hold", 32'(done0), 32'd1);
    adv(1'b0);
    settle(1'b0, 1'b1);
    chk("t4_done_clear", 32'(done0), 32'd0);
    chk("t4_idle_noinc", 32'(pcInc0), 32'd0);
    adv(1'b0);
    run0 = 1'b1;
    settle(1'b0, 1'b1);
    chk("t4_idle_first", 32'(pcInc0), 32'd0);
    adv(1'b0);
    settle(1'b0, 1'b1);
    chk("t4_refetch_inc", 32'(pcInc0), 32'd1);
    chk("t4_refetch_addr", 32'(romAddr0), 32'd0);
    adv(1'b0);
    run0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle(1'b0, 1'b1);
      adv(1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
